// File: rtl/fpio_ser_pkg.sv
// fpio_ser_pkg
// Shared types and constants for the FPIO serial stages.
//   fetch_state_e : states of the FIFO fetch FSM
//   tx_state_e    : states of the serial transmit FSM
//   LINE_*        : serial line levels for idle, start bit and stop bit
// Optional feature macro: FPIO_SER_TX_PARITY_EN adds the T_PAR state.
package fpio_ser_pkg;

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_REQ    = 2'd1,
        F_WAIT   = 2'd2,
        F_SETTLE = 2'd3
    } fetch_state_e;

    typedef enum logic [2:0] {
        T_IDLE  = 3'd0,
        T_START = 3'd1,
        T_DATA  = 3'd2,
`ifdef FPIO_SER_TX_PARITY_EN
        T_PAR   = 3'd3,
`endif
        T_STOP  = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/fpio_ser_bitclk.sv
// fpio_ser_bitclk
// Bit-period down-counter. A bit lasts period+1 cycles; tick marks the last
// cycle of each bit. Shared by transmit and (future) receive stages.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   load      : force the counter to period (start of a new bit stream)
//   period    : reload value (bit period minus one)
//   run       : counter active; when low the counter holds and tick is 0
//   tick      : terminal count, high on the last cycle of a bit
module fpio_ser_bitclk #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic                 run,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    assign tick = run && (cnt == '0);

    // Load wins over the automatic reload so a new stream restarts cleanly
    // even when it begins on the terminal cycle of the previous bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= period;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= period;
            end else begin
                cnt <= cnt - DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/fpio_ser_tx.sv
// fpio_ser_tx
// Serial transmit stage fed by the FPIO FIFO. A fetch FSM prefetches one word
// into a holding register; a transmit FSM frames it as start bit, DATA_WIDTH
// data bits LSB first, optional parity bit and stop bit, each bit lasting
// bit_div+1 cycles (bit_div latched at frame start).
// Optional feature macro: FPIO_SER_TX_PARITY_EN (adds parity bit and the
// parity_odd input).
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   fifo_avail    : words held in the upstream FIFO
//   fifo_data     : word at the FIFO read pointer
//   fifo_data_en  : one-cycle pop request
//   fifo_data_ack : pop acknowledge, the cycle after fifo_data_en
//   enable        : allows new fetches
//   bit_div       : bit period minus one
//   parity_odd    : (parity build only) odd parity select, sampled at frame start
//   ser_out       : registered serial line, idles high
//   busy          : frame in progress, word held or fetch in flight
//   frame_done    : one-cycle pulse after each stop bit
module fpio_ser_tx
    import fpio_ser_pkg::*;
#(
    parameter int FIFO_BITS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [FIFO_BITS:0]    fifo_avail,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_data_en,
    input  logic                  fifo_data_ack,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  bit_div,
`ifdef FPIO_SER_TX_PARITY_EN
    input  logic                  parity_odd,
`endif
    output logic                  ser_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    fetch_state_e          fstate, fstate_d;
    tx_state_e             tstate, tstate_d;

    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_valid;
    logic                  capture;

    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic [IDX_W-1:0]      bit_idx, bit_idx_d;
    logic [DIV_WIDTH-1:0]  div_q;
    logic                  start_frame;
    logic                  done_d;
    logic                  line_d;
    logic                  tick;

`ifdef FPIO_SER_TX_PARITY_EN
    logic                  par_q;
`endif

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fstate <= F_IDLE;
        end else begin
            fstate <= fstate_d;
        end
    end

    // An ack outside F_WAIT is ignored; F_SETTLE gives fifo_avail a cycle to
    // reflect the pop before another request is considered.
    always_comb begin
        fstate_d = fstate;
        capture  = 1'b0;
        case (fstate)
            F_IDLE: begin
                if (!hold_valid && enable && (fifo_avail != '0)) begin
                    fstate_d = F_REQ;
                end
            end
            F_REQ: begin
                fstate_d = F_WAIT;
            end
            F_WAIT: begin
                if (fifo_data_ack) begin
                    capture  = 1'b1;
                    fstate_d = F_SETTLE;
                end
            end
            F_SETTLE: begin
                fstate_d = F_IDLE;
            end
            default: begin
                fstate_d = F_IDLE;
            end
        endcase
    end

    assign fifo_data_en = (fstate == F_REQ);

    // ------------------------------------------------------------------
    // Transmit FSM next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        tstate_d    = tstate;
        shreg_d     = shreg;
        bit_idx_d   = bit_idx;
        start_frame = 1'b0;
        done_d      = 1'b0;
        case (tstate)
            T_IDLE: begin
                if (hold_valid) begin
                    start_frame = 1'b1;
                    tstate_d    = T_START;
                end
            end
            T_START: begin
                if (tick) begin
                    tstate_d  = T_DATA;
                    bit_idx_d = '0;
                end
            end
            T_DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_IDX) begin
`ifdef FPIO_SER_TX_PARITY_EN
                        tstate_d = T_PAR;
`else
                        tstate_d = T_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + IDX_W'(1);
                        shreg_d   = shreg >> 1;
                    end
                end
            end
`ifdef FPIO_SER_TX_PARITY_EN
            T_PAR: begin
                if (tick) begin
                    tstate_d = T_STOP;
                end
            end
`endif
            T_STOP: begin
                if (tick) begin
                    done_d = 1'b1;
                    if (hold_valid) begin
                        start_frame = 1'b1;
                        tstate_d    = T_START;
                    end else begin
                        tstate_d = T_IDLE;
                    end
                end
            end
            default: begin
                tstate_d = T_IDLE;
            end
        endcase

        if (start_frame) begin
            shreg_d = hold_data;
        end

        // ser_out is registered, so it is driven from the state being entered.
        case (tstate_d)
            T_START: line_d = LINE_START;
            T_DATA:  line_d = shreg_d[0];
`ifdef FPIO_SER_TX_PARITY_EN
            T_PAR:   line_d = par_q;
`endif
            T_STOP:  line_d = LINE_STOP;
            default: line_d = LINE_IDLE;
        endcase
    end

    // Capture and consume can never coincide: a fetch only starts with the
    // holding register empty, and a frame only starts with it full.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tstate     <= T_IDLE;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            div_q      <= '0;
            ser_out    <= LINE_IDLE;
            frame_done <= 1'b0;
`ifdef FPIO_SER_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            tstate     <= tstate_d;
            shreg      <= shreg_d;
            bit_idx    <= bit_idx_d;
            ser_out    <= line_d;
            frame_done <= done_d;
            if (capture) begin
                hold_data  <= fifo_data;
                hold_valid <= 1'b1;
            end else if (start_frame) begin
                hold_valid <= 1'b0;
            end
            if (start_frame) begin
                div_q <= bit_div;
`ifdef FPIO_SER_TX_PARITY_EN
                par_q <= (^hold_data) ^ parity_odd;
`endif
            end
        end
    end

    // A new frame loads the live bit_div; within a frame the latched div_q
    // reloads each bit, so mid-frame bit_div changes are ignored.
    fpio_ser_bitclk #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_bitclk (
        .clk    (clk),
        .rstn   (rstn),
        .load   (start_frame),
        .period (start_frame ? bit_div : div_q),
        .run    (tstate != T_IDLE),
        .tick   (tick)
    );

    assign busy = (tstate != T_IDLE) || hold_valid || (fstate != F_IDLE);

endmodule

// File: tb/tb_fpio_ser_tx.sv
// tb_fpio_ser_tx
// Self-checking bench for fpio_ser_tx. A queue-based FIFO model feeds the
// DUT; the expected line waveform is built from frame rules (start, data LSB
// first, optional parity, stop, each bit held div+1 cycles, frames back to back).
module tb_fpio_ser_tx;

    localparam int FIFO_BITS  = 4;
    localparam int DATA_WIDTH = 8;
    localparam int DIV_WIDTH  = 16;
`ifdef FPIO_SER_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    localparam int FRAME_BITS = DATA_WIDTH + 2 + (HAS_PAR ? 1 : 0);

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  enable = 1'b0;
    logic [DIV_WIDTH-1:0]  bit_div = '0;
    logic [FIFO_BITS:0]    fifo_avail = '0;
    logic [DATA_WIDTH-1:0] fifo_data = '0;
    logic                  fifo_data_ack = 1'b0;
    logic                  fifo_data_en;
    logic                  ser_out;
    logic                  busy;
    logic                  frame_done;
`ifdef FPIO_SER_TX_PARITY_EN
    logic                  parity_odd = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic                  push_req = 1'b0;
    logic                  flush_req = 1'b0;
    logic [DATA_WIDTH-1:0] push_val = '0;
    logic [DATA_WIDTH-1:0] fifo_q[$];

    logic [DATA_WIDTH-1:0] run_words[$];
    int                    run_divs[$];

    always #5 clk = ~clk;

    fpio_ser_tx #(
        .FIFO_BITS  (FIFO_BITS),
        .DATA_WIDTH (DATA_WIDTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .fifo_avail    (fifo_avail),
        .fifo_data     (fifo_data),
        .fifo_data_en  (fifo_data_en),
        .fifo_data_ack (fifo_data_ack),
        .enable        (enable),
        .bit_div       (bit_div),
`ifdef FPIO_SER_TX_PARITY_EN
        .parity_odd    (parity_odd),
`endif
        .ser_out       (ser_out),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    // Upstream FIFO model: pop on request, ack and data one cycle later.
    always @(posedge clk) begin
        if (flush_req) begin
            fifo_q.delete();
        end else begin
            if (fifo_data_en && (fifo_q.size() > 0)) begin
                fifo_data <= fifo_q[0];
                void'(fifo_q.pop_front());
            end
            if (push_req) begin
                fifo_q.push_back(push_val);
            end
        end
        fifo_data_ack <= fifo_data_en;
        fifo_avail    <= (FIFO_BITS+1)'(fifo_q.size());
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic bit frameBit(input logic [DATA_WIDTH-1:0] w, input int b,
                                    input bit odd);
        bit par;
        par = (($countones(w) % 2) == 1) ^ odd;
        if (b == 0) return 1'b0;
        if (b <= DATA_WIDTH) return w[b-1];
        if (HAS_PAR && (b == DATA_WIDTH + 1)) return par;
        return 1'b1;
    endfunction

    task automatic doReset();
        rstn      = 1'b0;
        enable    = 1'b0;
        push_req  = 1'b0;
        flush_req = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset ser_out", 32'(ser_out), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset fifo_data_en", 32'(fifo_data_en), 32'd0);
        flush_req = 1'b0;
        rstn      = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        foreach (run_words[k]) begin
            push_req = 1'b1;
            push_val = run_words[k];
            @(negedge clk);
        end
        push_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Sends run_words with per-frame dividers run_divs; optionally drops
    // enable during frame 1 so only it and the prefetched word go out.
    task automatic runStream(input string name, input bit drop, input bit odd);
        int n, nfr, pos, total, en_count, first_en, drop_m;
        int starts[$];
        int lens[$];
        bit exp_line[$];
        bit exp_done[$];

        n   = run_words.size();
        nfr = (drop && n > 2) ? 2 : n;
        doReset();
        applyStimulus();

        pos = 4;
        for (int k = 0; k < nfr; k++) begin
            starts.push_back(pos);
            lens.push_back(FRAME_BITS * (run_divs[k] + 1));
            pos += FRAME_BITS * (run_divs[k] + 1);
        end
        total = pos + 8;
        for (int i = 0; i < total; i++) begin
            exp_line.push_back(1'b1);
            exp_done.push_back(1'b0);
        end
        for (int k = 0; k < nfr; k++) begin
            for (int b = 0; b < FRAME_BITS; b++) begin
                for (int r = 0; r <= run_divs[k]; r++) begin
                    exp_line[starts[k] + b * (run_divs[k] + 1) + r] =
                        frameBit(run_words[k], b, odd);
                end
            end
            exp_done[starts[k] + lens[k]] = 1'b1;
        end
        drop_m = (drop && n >= 2) ? int'($urandom_range(starts[0] + 1, starts[1])) : -1;

        bit_div = DIV_WIDTH'(run_divs[0]);
`ifdef FPIO_SER_TX_PARITY_EN
        parity_odd = odd;
`endif
        enable   = 1'b1;
        en_count = 0;
        first_en = -1;
        for (int i = 0; i < total; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("%s line[%0d]", name, i), 32'(ser_out), 32'(exp_line[i]));
            checkOutput($sformatf("%s done[%0d]", name, i), 32'(frame_done), 32'(exp_done[i]));
            if (fifo_data_en) begin
                en_count++;
                if (first_en < 0) first_en = i;
            end
            for (int k = 0; k < nfr; k++) begin
                if (i == starts[k] + lens[k] / 2) begin
                    checkOutput($sformatf("%s busy mid frame %0d", name, k), 32'(busy), 32'd1);
                end
                if ((i == starts[k] + 1) && (k + 1 < n)) begin
                    bit_div = DIV_WIDTH'(run_divs[k+1]);
                end
            end
            if (i == drop_m) enable = 1'b0;
        end
        checkOutput($sformatf("%s en pulses", name), 32'(en_count), 32'(nfr));
        checkOutput($sformatf("%s first en cycle", name), 32'(first_en), 32'd1);
        checkOutput($sformatf("%s fifo_avail left", name), 32'(fifo_avail), 32'(n - nfr));
        checkOutput($sformatf("%s busy at end", name), 32'(busy), 32'd0);
        enable = 1'b0;
    endtask

    task automatic resetMidFrame();
        int d, m, idx, en_count, lows;
        bit odd;
        run_words.delete();
        run_words.push_back(DATA_WIDTH'($urandom));
        run_words.push_back(DATA_WIDTH'($urandom));
        doReset();
        applyStimulus();
        d   = $urandom_range(0, 3);
        odd = 1'b0;
        bit_div = DIV_WIDTH'(d);
        enable  = 1'b1;
        m = 4 + (d + 1) + int'($urandom_range(0, DATA_WIDTH * (d + 1) - 1));
        repeat (m) @(negedge clk);
        idx = (m - 4) / (d + 1);
        checkOutput("rst pre-reset data bit", 32'(ser_out), 32'(frameBit(run_words[0], idx, odd)));
        rstn   = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        checkOutput("rst ser_out", 32'(ser_out), 32'd1);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst frame_done", 32'(frame_done), 32'd0);
        rstn     = 1'b1;
        en_count = 0;
        lows     = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_data_en) en_count++;
            if (!ser_out) lows++;
        end
        checkOutput("rst en pulses after", 32'(en_count), 32'd0);
        checkOutput("rst line low cycles after", 32'(lows), 32'd0);
        checkOutput("rst busy after", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        run_words = '{8'hA5};
        run_divs  = '{0};
        runStream("single", 1'b0, 1'b0);

        run_words = '{8'h01, 8'hFF};
        run_divs  = '{3, 3};
        runStream("b2b", 1'b0, 1'b0);

        run_words = '{DATA_WIDTH'($urandom), DATA_WIDTH'($urandom)};
        run_divs  = '{1, 7};
        runStream("divlatch", 1'b0, 1'b0);

        run_words = '{DATA_WIDTH'($urandom), DATA_WIDTH'($urandom), DATA_WIDTH'($urandom)};
        run_divs  = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0};
        runStream("endrop", 1'b1, 1'b0);

        resetMidFrame();

        if (HAS_PAR) begin
            run_words = '{8'h07, 8'h07};
            run_divs  = '{0, 0};
            runStream("par even", 1'b0, 1'b0);
            runStream("par odd", 1'b0, 1'b1);
        end

        for (int r = 0; r < 4; r++) begin
            run_words.delete();
            run_divs.delete();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                run_words.push_back(DATA_WIDTH'($urandom));
                run_divs.push_back(int'($urandom_range(0, 4)));
            end
            runStream($sformatf("rand%0d", r), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpio_ser_tx.md
# fpio_ser_tx

Serial transmit stage that sits directly downstream of the FPIO FIFO. It pops DATA_WIDTH-bit words through the FIFO's consumer handshake (avail / data_en / data_ack / data) and shifts each word out on a single pin as a framed, rate-paced serial stream. The block keeps one prefetched word in a holding register, so back-to-back frames go out with no idle gap while the FIFO has data.

## Interface
Parameters:
- FIFO_BITS, 4, log2 of upstream FIFO depth; fifo_avail is FIFO_BITS+1 bits
- DATA_WIDTH, 8, bits per word and per frame payload
- DIV_WIDTH, 16, width of the bit-period divider

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- fifo_avail  in  FIFO_BITS+1  words held in the upstream FIFO
- fifo_data  in  DATA_WIDTH  word at the FIFO read pointer
- fifo_data_en  out  1  pop request, one-cycle pulse
- fifo_data_ack  in  1  pop acknowledge; high the cycle after fifo_data_en
- enable  in  1  transmit enable
- bit_div  in  DIV_WIDTH  bit period is bit_div+1 clk cycles
- ser_out  out  1  serial line, registered, idles high
- busy  out  1  frame in progress or word held
- frame_done  out  1  one-cycle pulse at the end of each stop bit

## Operation
- Reset values: ser_out=1, busy=0, frame_done=0, fifo_data_en=0. Holding register is empty. FSM is in IDLE.
- Fetch FSM (F_IDLE, F_REQ, F_WAIT, F_SETTLE):
  - F_IDLE→F_REQ when the holding register is empty, enable=1, and fifo_avail!=0.
  - F_REQ drives fifo_data_en=1 for exactly one cycle, then goes to F_WAIT.
  - In F_WAIT, when fifo_data_ack=1, capture fifo_data into the holding register, set hold_valid, and go to F_SETTLE.
  - F_SETTLE is one dead cycle that lets fifo_avail update, then returns to F_IDLE.
  - Never issue fifo_data_en while the fetch FSM is outside F_IDLE.
- Transmit FSM (T_IDLE, T_START, T_DATA, T_PAR, T_STOP):
  - T_IDLE→T_START when hold_valid=1. On this transition, move the holding register into the shift register, clear hold_valid, and latch bit_div into div_q.
  - Each bit lasts div_q+1 cycles, counted by a DIV_WIDTH down-counter.
  - T_START drives 0.
  - T_DATA sends DATA_WIDTH bits LSB first; a bit index counter runs 0..DATA_WIDTH-1.
  - T_STOP drives 1.
  - At the end of T_STOP, pulse frame_done. Then go to T_START if hold_valid=1 (no gap), else to T_IDLE.
- enable=0 only blocks new fetches. A held word and the current frame both complete. enable does not gate T_IDLE→T_START.
- busy = (tx state != T_IDLE) | hold_valid | (fetch state != F_IDLE).
- A bit_div change mid-frame has no effect until the next frame's start.
- If fifo_data_ack arrives when not in F_WAIT, ignore it.
- If fifo_avail is 0 mid-stream, the line returns to idle-high after the stop bit.
- Synchronous reset mid-frame: ser_out goes to 1 on the next edge. All state is cleared and the held word is discarded.

## Timing
- Cycle 0: enable=1, fifo_avail>0, FIFO empty of pending fetches. fifo_data_en is high in cycle 1.
- Ack arrives in cycle 2; the word is captured at the end of cycle 2.
- T_START begins in cycle 3: ser_out is low from the cycle 4 edge.
- Frame length is (DATA_WIDTH+2)*(div_q+1) cycles, or (DATA_WIDTH+3)*(div_q+1) with parity.
- bit_div=0 gives one cycle per bit.
- The next-word prefetch overlaps the current frame. Frames are back-to-back whenever the fetch completes (4 cycles) before the stop bit ends. With bit_div=0, that holds for DATA_WIDTH≥2.

## Configuration
- FPIO_SER_TX_PARITY_EN defined:
  - Adds T_PAR between T_DATA and T_STOP.
  - Adds input parity_odd (1 bit, sampled at frame start).
  - The parity bit is the XOR of the data bits, inverted when parity_odd=1.
- FPIO_SER_TX_PARITY_EN undefined: there is no T_PAR state and no parity_odd port; T_DATA goes directly to T_STOP.

## Structure
- Package fpio_ser_pkg holds:
  - fetch_state_e and tx_state_e enums.
  - Localparam constants for the line idle level (1), start level (0) and stop level (1).
- Sub-module fpio_ser_bitclk: DIV_WIDTH down-counter with load and a terminal-count tick output. It is reusable by a future receive stage.
- The fetch and transmit FSMs live in the top module.

## Test plan
- Single word: DATA_WIDTH=8, bit_div=0, FIFO holds 0xA5 → ser_out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, then one frame_done pulse, then fifo_data_en stays 0.
- Back-to-back: FIFO holds 0x01 and 0xFF, bit_div=3 → two 40-cycle frames with no idle cycle between them. Exactly two fifo_data_en pulses occur.
- Divider latch: bit_div changes from 1 to 7 mid-frame → the current frame keeps 2-cycle bits and the next frame uses 8-cycle bits.
- Enable drop: enable→0 during frame 1 with 3 words queued → frame 1 and the held word complete, then the line stays idle high and fifo_avail=1 remains.
- Reset mid-frame: rstn=0 during T_DATA → ser_out=1, busy=0, frame_done=0 on the next edge, and no further fifo_data_en pulses.
- Parity (macro on): parity_odd=0, 0x07 → parity bit 1; parity_odd=1 → parity bit 0. Frame is 11 bits.
